// File: rtl/dac_pkg.sv
// Shared constants for the DAC081S101-style serial transmitter: power-down codes, frame layout, FSM encodings.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dac_pkg;

  // Power-down field values carried in the frame
  localparam logic [1:0] PD_NORMAL = 2'b00;
  localparam logic [1:0] PD_1K     = 2'b01;
  localparam logic [1:0] PD_100K   = 2'b10;
  localparam logic [1:0] PD_HIZ    = 2'b11;

  // Frame layout: {2'b00, pd[1:0], data[7:0], 4'b0000}, bit 15 first on the wire
  localparam int FRAME_BITS = 16;
  localparam int PD_MSB     = 13;
  localparam int PD_LSB     = 12;
  localparam int DATA_MSB   = 11;
  localparam int DATA_LSB   = 4;

  // Transmitter FSM encodings
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  // Assemble the 16-bit word the DAC expects from a code and a power-down mode
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] code,
                                                         input logic [1:0] pd);
    logic [FRAME_BITS-1:0] w;
    w = '0;
    w[PD_MSB:PD_LSB]     = pd;
    w[DATA_MSB:DATA_LSB] = code;
    return w;
  endfunction

endpackage

// File: rtl/sclk_tick_gen.sv
// Clock-enable tick generator: pulses tick for one clk_in cycle every CLK_DIV enabled cycles.
// Latency: first tick CLK_DIV cycles after enable rises from a cleared count.
// Backpressure: none; count freezes while en is low, clr forces it back to zero.
module sclk_tick_gen #(
  parameter int CLK_DIV = 12
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [7:0] CNT_LAST = 8'(CLK_DIV - 1);

  logic [7:0] div_cnt;

  // Free-running modulo-CLK_DIV counter, gated by en and reset by clr
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      div_cnt <= 8'd0;
    end else if (clr) begin
      div_cnt <= 8'd0;
    end else if (en) begin
      if (div_cnt == CNT_LAST) div_cnt <= 8'd0;
      else                     div_cnt <= div_cnt + 8'd1;
    end
  end

  assign tick = en && (div_cnt == CNT_LAST);

endmodule

// File: rtl/dac_8bit_tx.sv
// Serial transmitter for an 8-bit SPI-style DAC: one 16-bit MSB-first frame per accepted request.
// Latency: done pulses 1 + (32+GAP_HALVES)*CLK_DIV cycles after acceptance.
// Backpressure: wr_ready low from acceptance until done; requests meanwhile are ignored, not queued.
module dac_8bit_tx
  import dac_pkg::*;
#(
  parameter int CLK_DIV    = 12,
  parameter int GAP_HALVES = 2
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       wr_valid,
  input  logic [7:0] wr_data,
  input  logic [1:0] pd_mode,
  output logic       wr_ready,
  output logic       done,
  output logic       dac_sclk,
  output logic       dac_syncn,
  output logic       dac_din
);

  localparam logic [7:0] GAP_LAST = 8'(GAP_HALVES - 1);
  localparam logic [3:0] BIT_LAST = 4'(FRAME_BITS - 1);

  logic [1:0]            state;
  logic [FRAME_BITS-1:0] shreg;
  logic [FRAME_BITS-1:0] frame_word;
  logic [3:0]            bit_cnt;
  logic [7:0]            gap_cnt;
  logic                  last;
  logic                  tick;
  logic                  div_en;
  logic                  div_clr;

  assign frame_word = build_frame(wr_data, pd_mode);
  // Divider only runs while a frame or its trailing gap is in progress; IDLE holds it at zero
  // so each frame starts from a fresh half-period. SHIFT->GAP and GAP->IDLE happen on a tick,
  // where the counter wraps to zero anyway.
  assign div_en  = (state == ST_SHIFT) || (state == ST_GAP);
  assign div_clr = (state == ST_IDLE);

  sclk_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .en       (div_en),
    .clr      (div_clr),
    .tick     (tick)
  );

  // Frame sequencer: load on accept, toggle SCLK per tick, advance data on rising SCLK only
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state     <= ST_IDLE;
      wr_ready  <= 1'b1;
      done      <= 1'b0;
      dac_sclk  <= 1'b1;
      dac_syncn <= 1'b1;
      dac_din   <= 1'b0;
      shreg     <= '0;
      bit_cnt   <= 4'd0;
      gap_cnt   <= 8'd0;
      last      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (wr_valid && wr_ready) begin
            shreg     <= frame_word;
            dac_syncn <= 1'b0;
            dac_din   <= frame_word[FRAME_BITS-1];
            bit_cnt   <= 4'd0;
            last      <= 1'b0;
            wr_ready  <= 1'b0;
            state     <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (tick) begin
            if (dac_sclk) begin
              // Falling edge: DAC samples the bit currently on dac_din
              dac_sclk <= 1'b0;
              if (bit_cnt == BIT_LAST) last <= 1'b1;
            end else begin
              dac_sclk <= 1'b1;
              if (last) begin
                dac_syncn <= 1'b1;
                dac_din   <= 1'b0;
                gap_cnt   <= 8'd0;
                state     <= ST_GAP;
              end else begin
                shreg   <= shreg << 1;
                dac_din <= shreg[FRAME_BITS-2];
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end
        end
        ST_GAP: begin
          if (tick) begin
            if (gap_cnt == GAP_LAST) begin
              done     <= 1'b1;
              wr_ready <= 1'b1;
              state    <= ST_IDLE;
            end else begin
              gap_cnt <= gap_cnt + 8'd1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dac_8bit_tx.sv
// Bench for dac_8bit_tx: DAC-side capture model, timing and protocol checks, directed and random frames.
// Latency: default CLK_DIV=12, GAP_HALVES=2 assumed by the timing expectations.
// Backpressure: stimulus waits on wr_ready with bounded loops.
module tb_dac_8bit_tx;

  logic       clk_in   = 1'b0;
  logic       rst_n_in = 1'b1;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_data  = 8'h00;
  logic [1:0] pd_mode  = 2'b00;
  logic       wr_ready, done, dac_sclk, dac_syncn, dac_din;

  int errors = 0;
  int checks = 0;

  always #5 clk_in = ~clk_in;

  dac_8bit_tx dut (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .wr_valid  (wr_valid),
    .wr_data   (wr_data),
    .pd_mode   (pd_mode),
    .wr_ready  (wr_ready),
    .done      (done),
    .dac_sclk  (dac_sclk),
    .dac_syncn (dac_syncn),
    .dac_din   (dac_din)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model / monitor (samples on falling clk_in) ----------------
  int          cyc = 0;
  logic        p_sclk = 1'b1, p_sync = 1'b1, p_din = 1'b0, p_done = 1'b0;
  int          falls = 0;
  logic [15:0] cap = 16'h0;
  logic [15:0] last_word = 16'h0;
  logic [15:0] expq[$];
  int          fall_cyc = 0, rise_cyc = -1, last_gap = -1, accept_cyc = -1;
  int          done_cnt = 0, aborted = 0, last_abort_falls = -1;

  always @(posedge clk_in) cyc <= cyc + 1;

  always @(negedge clk_in) begin
    if (p_sync && !dac_syncn) begin
      falls = 0;
      cap   = 16'h0;
      fall_cyc = cyc;
      if (rise_cyc >= 0) begin
        last_gap = cyc - rise_cyc;
        chk("sync_gap_min", 32'(last_gap >= 25), 1);
      end
    end
    if (!dac_syncn && p_sclk && !dac_sclk) begin
      chk("din_stable_on_fall", 32'(dac_din), 32'(p_din));
      cap = {cap[14:0], p_din};
      falls++;
    end
    if (!p_sync && dac_syncn) begin
      if (!rst_n_in) begin
        aborted++;
        last_abort_falls = falls;
        if (expq.size() > 0) void'(expq.pop_front());
        rise_cyc   = -1;
        accept_cyc = -1;
      end else begin
        chk("falls_per_frame", 32'(falls), 16);
        chk("sync_low_cycles", 32'(cyc - fall_cyc), 384);
        chk("frame_expected", 32'(expq.size() > 0), 1);
        if (expq.size() > 0) chk("frame_word", 32'(cap), 32'(expq.pop_front()));
        last_word = cap;
        rise_cyc  = cyc;
      end
    end
    if (done) begin
      done_cnt++;
      chk("done_one_cycle", 32'(p_done), 0);
      if (accept_cyc >= 0) chk("accept_to_done", 32'(cyc - accept_cyc), 409);
    end
    if (wr_valid && wr_ready && rst_n_in) begin
      accept_cyc = cyc;
      expq.push_back(16'((int'(pd_mode) << 12) + (int'(wr_data) << 4)));
    end
    p_sclk = dac_sclk;
    p_sync = dac_syncn;
    p_din  = dac_din;
    p_done = done;
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [7:0] d, input logic [1:0] p, input bit scramble);
    int n = 0;
    @(posedge clk_in); #2;
    wr_valid = 1'b1; wr_data = d; pd_mode = p;
    while (!wr_ready && n < 1000) begin
      @(posedge clk_in); #2; n++;
    end
    chk("accept_timeout", 32'(n < 1000), 1);
    @(posedge clk_in); #2;
    wr_valid = 1'b0;
    if (scramble) begin
      repeat (50) @(posedge clk_in);
      #2;
      wr_data = ~d; pd_mode = ~p;
    end
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 2000) begin
      @(posedge clk_in); #3; n++;
    end
    chk(tag, 32'(done), 1);
    @(posedge clk_in); #2;
  endtask

  initial begin
    int d0, n;
    #1 rst_n_in = 1'b0;
    repeat (3) @(posedge clk_in);
    #3 rst_n_in = 1'b1;
    chk("reset_state", {dac_sclk, dac_syncn, dac_din, wr_ready, done}, 5'b11010);

    // idle: bus parked for 100 cycles
    repeat (100) begin
      @(posedge clk_in); #3;
      chk("idle_outputs", {dac_sclk, dac_syncn, dac_din, wr_ready, done}, 5'b11010);
    end

    // basic frame
    send(8'hA5, 2'b00, 1'b0);
    wait_done("done_a5");
    chk("word_a5", 32'(last_word), 32'h0A50);

    // Hi-Z with inputs changed mid-frame
    send(8'hFF, 2'b11, 1'b1);
    wait_done("done_ff");
    chk("word_ff_hiz", 32'(last_word), 32'h3FF0);

    // back-to-back with wr_valid held high
    d0 = done_cnt;
    @(posedge clk_in); #2;
    wr_valid = 1'b1; wr_data = 8'h01; pd_mode = 2'b00;
    n = 0;
    while (wr_ready && n < 100) begin @(posedge clk_in); #2; n++; end
    chk("b2b_accept1", 32'(wr_ready), 0);
    wr_data = 8'h80;
    wait_done("b2b_done1");
    chk("b2b_word1", 32'(last_word), 32'h0010);
    #1;
    chk("b2b_ready_after_done", 32'(wr_ready), 0);
    wr_valid = 1'b0;
    wait_done("b2b_done2");
    chk("b2b_word2", 32'(last_word), 32'h0800);
    chk("b2b_sync_gap", 32'(last_gap), 25);
    repeat (40) @(posedge clk_in);
    #3;
    chk("b2b_done_count", 32'(done_cnt - d0), 2);

    // asynchronous reset at the 7th falling SCLK edge
    @(posedge clk_in); #2;
    wr_valid = 1'b1; wr_data = 8'h5A; pd_mode = 2'b10;
    n = 0;
    while (wr_ready && n < 100) begin @(posedge clk_in); #2; n++; end
    wr_valid = 1'b0;
    @(posedge clk_in); #3;
    n = 0;
    while (falls < 7 && n < 1000) begin @(posedge clk_in); #3; n++; end
    chk("rst_reached_fall7", 32'(falls), 7);
    d0 = done_cnt;
    rst_n_in = 1'b0;
    #1;
    chk("rst_async_outputs", {dac_sclk, dac_syncn, dac_din, wr_ready, done}, 5'b11010);
    repeat (3) @(posedge clk_in);
    #3 rst_n_in = 1'b1;
    repeat (30) @(posedge clk_in);
    #3;
    chk("rst_no_done", 32'(done_cnt - d0), 0);
    chk("rst_aborted", 32'(aborted), 1);
    chk("rst_abort_falls", 32'(last_abort_falls), 7);
    send(8'h3C, 2'b01, 1'b0);
    wait_done("done_after_rst");
    chk("word_after_rst", 32'(last_word), 32'h13C0);

    // randomized frames against the queue model
    for (int i = 0; i < 10; i++) begin
      logic [7:0] rd;
      logic [1:0] rp;
      rd = 8'($urandom);
      rp = 2'($urandom_range(0, 3));
      repeat ($urandom_range(0, 20)) @(posedge clk_in);
      send(rd, rp, 1'($urandom_range(0, 1)));
      wait_done("done_rand");
      chk("word_rand", 32'(last_word), 32'((int'(rp) << 12) + (int'(rd) << 4)));
    end

    repeat (20) @(posedge clk_in);
    #3;
    chk("model_queue_empty", 32'(expq.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
